// File: rtl/alarm_setter.sv
// ---------------------------------------------------------------------------
// alarm_setter
//   Three-button alarm time editor. MODE walks IDLE -> EDIT_H -> EDIT_M ->
//   COMMIT -> IDLE. In EDIT_H/EDIT_M, INC/DEC step a working copy with wrap.
//   COMMIT copies the working copy to the committed alarm time and pulses
//   set_alarm for one cycle. An edit left untouched for TIMEOUT_CYCLES is
//   abandoned without committing.
//
//   Optional feature macro: ALARM_SETTER_AUTOREPEAT_EN
//     When defined, holding INC or DEC alone auto-steps REPEAT_DELAY cycles
//     after the press and then every REPEAT_PERIOD cycles while held.
//
// Ports
//   clk          in   single clock, rising edge
//   rst          in   asynchronous active-low reset
//   btn_mode     in   debounced, synchronous; advances the edit field
//   btn_inc      in   debounced, synchronous; increments the field
//   btn_dec      in   debounced, synchronous; decrements the field
//   set_hours    out  committed alarm hours 0..23
//   set_minutes  out  committed alarm minutes 0..59
//   set_alarm    out  one-cycle commit strobe
//   edit_field   out  00 idle, 01 hours, 10 minutes
//   edit_hours   out  working copy of hours
//   edit_minutes out  working copy of minutes
// ---------------------------------------------------------------------------
module alarm_setter #(
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter int REPEAT_DELAY   = 25_000_000,
    parameter int REPEAT_PERIOD  = 5_000_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                btn_mode,
    input  logic                btn_inc,
    input  logic                btn_dec,
    output logic [$clog2(24):0] set_hours,
    output logic [$clog2(60):0] set_minutes,
    output logic                set_alarm,
    output logic [1:0]          edit_field,
    output logic [$clog2(24):0] edit_hours,
    output logic [$clog2(60):0] edit_minutes
);

    localparam int HW = $clog2(24) + 1;
    localparam int MW = $clog2(60) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_EDIT_H = 2'b01,
        ST_EDIT_M = 2'b10,
        ST_COMMIT = 2'b11
    } state_t;

    // Elaboration-time sanity check of the timing parameters.
    if (TIMEOUT_CYCLES < 1 || REPEAT_PERIOD < 1 || REPEAT_DELAY < REPEAT_PERIOD) begin : g_bad_cfg
        $error("alarm_setter: invalid timing parameters");
    end

    // Hours step with wrap 23 <-> 0.
    function automatic logic [HW-1:0] f_hours_step(input logic [HW-1:0] v, input logic up);
        logic [HW-1:0] r;
        if (up) begin
            r = (v == 6'd23) ? 6'd0 : v + 6'd1;
        end else begin
            r = (v == 6'd0) ? 6'd23 : v - 6'd1;
        end
        return r;
    endfunction

    // Minutes step with wrap 59 <-> 0.
    function automatic logic [MW-1:0] f_minutes_step(input logic [MW-1:0] v, input logic up);
        logic [MW-1:0] r;
        if (up) begin
            r = (v == 7'd59) ? 7'd0 : v + 7'd1;
        end else begin
            r = (v == 7'd0) ? 7'd59 : v - 7'd1;
        end
        return r;
    endfunction

    state_t          r_state;
    logic            r_mode_q;
    logic            r_inc_q;
    logic            r_dec_q;
    logic [TW-1:0]   r_to_cnt;
    logic [HW-1:0]   r_set_hours;
    logic [MW-1:0]   r_set_minutes;
    logic            r_set_alarm;
    logic [1:0]      r_edit_field;
    logic [HW-1:0]   r_edit_hours;
    logic [MW-1:0]   r_edit_minutes;

    logic            w_mode_p;
    logic            w_inc_p;
    logic            w_dec_p;
    logic            w_edit_st;
    logic            w_rep_step;
    logic            w_up;
    logic            w_dn;
    logic            w_act;

    // Rising-edge press detection; a held level never counts as a new press.
    assign w_mode_p  = btn_mode & ~r_mode_q;
    assign w_inc_p   = btn_inc  & ~r_inc_q;
    assign w_dec_p   = btn_dec  & ~r_dec_q;
    assign w_edit_st = (r_state == ST_EDIT_H) || (r_state == ST_EDIT_M);

`ifdef ALARM_SETTER_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_DELAY + 1);
    localparam logic [RW-1:0] REP_LAST   = RW'(REPEAT_DELAY - 1);
    // After the first repeat the counter restarts part-way so later steps
    // come every REPEAT_PERIOD cycles.
    localparam logic [RW-1:0] REP_RELOAD = RW'(REPEAT_DELAY - REPEAT_PERIOD);

    logic [RW-1:0] r_rep_cnt;
    logic          w_rep_run;

    // Repeat runs only while exactly one of inc/dec is held with no new press.
    assign w_rep_run  = w_edit_st & (btn_inc ^ btn_dec) & ~w_mode_p & ~w_inc_p & ~w_dec_p;
    assign w_rep_step = w_rep_run & (r_rep_cnt == REP_LAST);

    // Hold-time counter for auto-repeat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rep_cnt <= '0;
        end else if (!w_rep_run) begin
            r_rep_cnt <= '0;
        end else if (r_rep_cnt == REP_LAST) begin
            r_rep_cnt <= REP_RELOAD;
        end else begin
            r_rep_cnt <= r_rep_cnt + RW'(1);
        end
    end
`else
    assign w_rep_step = 1'b0;
`endif

    // Simultaneous inc+dec presses cancel; a repeat step follows the held button.
    assign w_up  = (w_inc_p & ~w_dec_p) | (w_rep_step & btn_inc);
    assign w_dn  = (w_dec_p & ~w_inc_p) | (w_rep_step & btn_dec);
    assign w_act = w_inc_p | w_dec_p | w_rep_step;

    // Edit FSM: state, working copy, committed time, timeout and strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= ST_IDLE;
            r_mode_q       <= 1'b0;
            r_inc_q        <= 1'b0;
            r_dec_q        <= 1'b0;
            r_to_cnt       <= '0;
            r_set_hours    <= 6'd0;
            r_set_minutes  <= 7'd0;
            r_set_alarm    <= 1'b0;
            r_edit_field   <= 2'b00;
            r_edit_hours   <= 6'd0;
            r_edit_minutes <= 7'd0;
        end else begin
            r_mode_q    <= btn_mode;
            r_inc_q     <= btn_inc;
            r_dec_q     <= btn_dec;
            r_set_alarm <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_to_cnt <= '0;
                    if (w_mode_p) begin
                        r_edit_hours   <= r_set_hours;
                        r_edit_minutes <= r_set_minutes;
                        r_state        <= ST_EDIT_H;
                        r_edit_field   <= 2'b01;
                    end else begin
                        r_edit_field   <= 2'b00;
                    end
                end
                ST_EDIT_H, ST_EDIT_M: begin
                    if (w_mode_p) begin
                        // Mode wins over inc/dec in the same cycle.
                        r_to_cnt <= '0;
                        if (r_state == ST_EDIT_H) begin
                            r_state      <= ST_EDIT_M;
                            r_edit_field <= 2'b10;
                        end else begin
                            r_state       <= ST_COMMIT;
                            r_edit_field  <= 2'b00;
                            r_set_hours   <= r_edit_hours;
                            r_set_minutes <= r_edit_minutes;
                            r_set_alarm   <= 1'b1;
                        end
                    end else if (w_act) begin
                        r_to_cnt <= '0;
                        if (w_up || w_dn) begin
                            if (r_state == ST_EDIT_H) begin
                                r_edit_hours <= f_hours_step(r_edit_hours, w_up);
                            end else begin
                                r_edit_minutes <= f_minutes_step(r_edit_minutes, w_up);
                            end
                        end else begin
                            r_edit_hours <= r_edit_hours;
                        end
                    end else if (r_to_cnt == TO_LAST) begin
                        // Abandon the edit; committed time is untouched.
                        r_to_cnt     <= '0;
                        r_state      <= ST_IDLE;
                        r_edit_field <= 2'b00;
                    end else begin
                        r_to_cnt <= r_to_cnt + TW'(1);
                    end
                end
                ST_COMMIT: begin
                    r_to_cnt     <= '0;
                    r_state      <= ST_IDLE;
                    r_edit_field <= 2'b00;
                end
                default: begin
                    r_to_cnt     <= '0;
                    r_state      <= ST_IDLE;
                    r_edit_field <= 2'b00;
                end
            endcase
        end
    end

    assign set_hours    = r_set_hours;
    assign set_minutes  = r_set_minutes;
    assign set_alarm    = r_set_alarm;
    assign edit_field   = r_edit_field;
    assign edit_hours   = r_edit_hours;
    assign edit_minutes = r_edit_minutes;

endmodule

// File: tb/tb_alarm_setter.sv
// ---------------------------------------------------------------------------
// tb_alarm_setter
//   Scoreboard bench for alarm_setter. The driver applies one button vector
//   per cycle, advances an arithmetic reference model of the editor and
//   queues the expected outputs; a monitor pops and compares after each
//   rising edge, and a second queue matches every set_alarm strobe against
//   the committed time the model expects. Directed sequences cover the
//   documented cases, followed by randomized button traffic.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alarm_setter;

    localparam int TO = 100;
    localparam int RD = 20;
    localparam int RP = 4;
`ifdef ALARM_SETTER_AUTOREPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic       btn_dec = 1'b0;
    logic [5:0] set_hours;
    logic [6:0] set_minutes;
    logic       set_alarm;
    logic [1:0] edit_field;
    logic [5:0] edit_hours;
    logic [6:0] edit_minutes;

    alarm_setter #(
        .TIMEOUT_CYCLES(TO),
        .REPEAT_DELAY  (RD),
        .REPEAT_PERIOD (RP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_mode    (btn_mode),
        .btn_inc     (btn_inc),
        .btn_dec     (btn_dec),
        .set_hours   (set_hours),
        .set_minutes (set_minutes),
        .set_alarm   (set_alarm),
        .edit_field  (edit_field),
        .edit_hours  (edit_hours),
        .edit_minutes(edit_minutes)
    );

    always #5 clk = ~clk;

    typedef struct { int sh; int sm; int al; int ef; int eh; int em; } exp_t;
    typedef struct { int h; int m; } com_t;
    exp_t exp_q[$];
    com_t com_q[$];

    int n_chk = 0;
    int n_err = 0;

    // Reference model: field 0 idle, 1 hours, 2 minutes, 3 commit.
    int md_field, md_sh, md_sm, md_eh, md_em, md_idle, md_hold;
    bit prv_m, prv_i, prv_d;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        md_field = 0; md_sh = 0; md_sm = 0; md_eh = 0; md_em = 0;
        md_idle = 0; md_hold = 0; prv_m = 0; prv_i = 0; prv_d = 0;
    endtask

    task automatic model_step(input bit m, input bit i, input bit d, output exp_t e);
        bit pm, pi, pd, act, al;
        int step;
        pm = m && !prv_m; pi = i && !prv_i; pd = d && !prv_d;
        prv_m = m; prv_i = i; prv_d = d;
        al = 0; act = 0; step = 0;
        if (md_field == 0) begin
            md_hold = 0;
            if (pm) begin
                md_eh = md_sh; md_em = md_sm; md_field = 1; md_idle = 0;
            end
        end else if (md_field == 3) begin
            md_hold = 0;
            md_field = 0;
        end else begin
            // cycles one button has been held alone since its press
            if (!pm && !pi && !pd && (i != d)) md_hold++;
            else md_hold = 0;
            if (pm) begin
                act = 1;
                if (md_field == 1) md_field = 2;
                else begin
                    md_sh = md_eh; md_sm = md_em; al = 1; md_field = 3;
                    com_q.push_back('{h: md_eh, m: md_em});
                end
            end else if (pi || pd) begin
                act = 1;
                step = (pi ? 1 : 0) - (pd ? 1 : 0);
            end else if (REP_EN && (i != d) && md_hold >= RD && ((md_hold - RD) % RP) == 0) begin
                act = 1;
                step = i ? 1 : -1;
            end
            if (md_field == 1) md_eh = (md_eh + step + 24) % 24;
            if (md_field == 2) md_em = (md_em + step + 60) % 60;
            if (act) md_idle = 0;
            else begin
                md_idle++;
                if (md_idle >= TO) begin md_field = 0; md_idle = 0; end
            end
        end
        e.sh = md_sh; e.sm = md_sm; e.al = al;
        e.ef = (md_field == 1) ? 1 : ((md_field == 2) ? 2 : 0);
        e.eh = md_eh; e.em = md_em;
    endtask

    // Drive one cycle of buttons and queue the expected response.
    task automatic cyc(input bit m, input bit i, input bit d);
        exp_t e;
        @(negedge clk);
        btn_mode = m; btn_inc = i; btn_dec = d;
        model_step(m, i, d, e);
        exp_q.push_back(e);
    endtask

    task automatic press(input bit m, input bit i, input bit d);
        cyc(m, i, d);
        cyc(1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_set_hours"}, set_hours, 0);
        chk({tag, "_set_minutes"}, set_minutes, 0);
        chk({tag, "_set_alarm"}, set_alarm, 0);
        chk({tag, "_edit_field"}, edit_field, 0);
        chk({tag, "_edit_hours"}, edit_hours, 0);
        chk({tag, "_edit_minutes"}, edit_minutes, 0);
    endtask

    // Monitor: compare queued expectations and commit strobes after each edge.
    always @(posedge clk) begin
        exp_t e;
        com_t c;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("mon_set_hours", set_hours, e.sh);
            chk("mon_set_minutes", set_minutes, e.sm);
            chk("mon_set_alarm", set_alarm, e.al);
            chk("mon_edit_field", edit_field, e.ef);
            chk("mon_edit_hours", edit_hours, e.eh);
            chk("mon_edit_minutes", edit_minutes, e.em);
        end
        if (set_alarm === 1'b1) begin
            if (com_q.size() == 0) begin
                n_chk++; n_err++;
                $display("FAIL commit_unexpected actual=1 expected=0 at %0t", $time);
            end else begin
                c = com_q.pop_front();
                chk("commit_hours", set_hours, c.h);
                chk("commit_minutes", set_minutes, c.m);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int h0;
        int expm;
        model_reset();
        // reset state
        #12;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;

        // timeout: enter EDIT_H, one inc, then idle
        press(1, 0, 0);
        cyc(0, 1, 0);
        @(posedge clk); #1;
        chk("to_edit_hours", edit_hours, 1);
        for (int k = 1; k <= TO; k++) begin
            cyc(0, 0, 0);
            @(posedge clk); #1;
            if (k == TO - 1) chk("to_before", edit_field, 1);
            if (k == TO) begin
                chk("to_field", edit_field, 0);
                chk("to_set_hours", set_hours, 0);
                chk("to_alarm", set_alarm, 0);
            end
        end

        // mode, 2x inc, mode, 3x dec, mode -> 02:57
        press(1, 0, 0);
        chk("seq_load_h", edit_hours, 0);
        press(0, 1, 0); press(0, 1, 0);
        press(1, 0, 0);
        press(0, 0, 1); press(0, 0, 1); press(0, 0, 1);
        cyc(1, 0, 0);
        @(posedge clk); #1;
        chk("seq_alarm", set_alarm, 1);
        chk("seq_hours", set_hours, 2);
        chk("seq_minutes", set_minutes, 57);
        cyc(0, 0, 0);
        @(posedge clk); #1;
        chk("seq_alarm_one", set_alarm, 0);

        // wraps
        press(1, 0, 0);
        press(0, 0, 1); press(0, 0, 1); press(0, 0, 1);
        chk("wrap_h_dec", edit_hours, 23);
        press(0, 1, 0);
        chk("wrap_h_inc", edit_hours, 0);
        press(1, 0, 0);
        press(0, 1, 0); press(0, 1, 0);
        chk("wrap_m59", edit_minutes, 59);
        press(0, 1, 0);
        chk("wrap_m_inc", edit_minutes, 0);
        press(0, 0, 1);
        chk("wrap_m_dec", edit_minutes, 59);
        press(1, 0, 0);

        // simultaneous presses and mode priority
        press(1, 0, 0);
        h0 = md_eh;
        press(0, 1, 1);
        chk("simul_h", edit_hours, h0);
        press(1, 1, 0);
        chk("modeinc_field", edit_field, 2);
        chk("modeinc_h", edit_hours, h0);
        n = md_em;
        press(0, 1, 1);
        chk("simul_m", edit_minutes, n);
        press(1, 0, 0);

        // reset mid-edit with minutes at 30
        press(1, 0, 0);
        press(1, 0, 0);
        n = (30 - md_em + 60) % 60;
        for (int k = 0; k < n; k++) press(0, 1, 0);
        chk("mid_em30", edit_minutes, 30);
        chk("mid_field", edit_field, 2);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        chk_all_zero("midrst");
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (5) cyc(0, 0, 0);

        // held inc in EDIT_M from 0
        press(1, 0, 0);
        press(1, 0, 0);
        cyc(0, 1, 0);
        @(posedge clk); #1;
        chk("hold_press", edit_minutes, 1);
        for (int k = 1; k <= 32; k++) begin
            cyc(0, 1, 0);
            @(posedge clk); #1;
            expm = (REP_EN && k >= RD) ? 2 + (k - RD) / RP : 1;
            if (k == 19 || k == 20 || k == 24 || k == 28 || k == 32)
                chk("hold_minutes", edit_minutes, expm);
        end
        cyc(0, 0, 0);
        press(1, 0, 0);

        // randomized traffic
        for (int k = 0; k < 800; k++) begin
            cyc($urandom_range(7) == 0, $urandom_range(3) == 0, $urandom_range(3) == 0);
        end

        repeat (3) cyc(0, 0, 0);
        @(posedge clk); #2;
        chk("sb_drain", exp_q.size(), 0);
        chk("commit_drain", com_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/alarm_setter.md
ALARM_SETTER -- requirements
Module: alarm_setter

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 50_000_000, meaning idle cycles in an edit state before edit is abandoned.
REQ-002 The block SHALL have parameter REPEAT_DELAY, default 25_000_000, meaning hold cycles before auto-repeat starts.
REQ-003 The block SHALL have parameter REPEAT_PERIOD, default 5_000_000, meaning cycles between auto-repeat steps.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port btn_mode, input, 1 bit: debounced, clk-synchronous, active-high; advances edit field.
REQ-007 The block SHALL have port btn_inc, input, 1 bit: debounced, clk-synchronous, active-high; increments the field under edit.
REQ-008 The block SHALL have port btn_dec, input, 1 bit: debounced, clk-synchronous, active-high; decrements the field under edit.
REQ-009 The block SHALL have port set_hours, output, [$clog2(24):0]: committed alarm hours, 0..23.
REQ-010 The block SHALL have port set_minutes, output, [$clog2(60):0]: committed alarm minutes, 0..59.
REQ-011 The block SHALL have port set_alarm, output, 1 bit: one-cycle commit strobe to the alarm comparator.
REQ-012 The block SHALL have port edit_field, output, 2 bits: 00 idle, 01 hours, 10 minutes; for display blinking.
REQ-013 The block SHALL have port edit_hours and edit_minutes, outputs, same widths as set_*: working copy being edited.

Function
REQ-014 The block SHALL detect button presses as rising edges (sampled low in the previous cycle, high now); levels SHALL NOT step values.
REQ-015 The FSM SHALL have states IDLE, EDIT_H, EDIT_M, COMMIT.
REQ-016 In IDLE, a btn_mode press SHALL load edit_hours/edit_minutes from set_hours/set_minutes and enter EDIT_H.
REQ-017 In EDIT_H, a btn_inc press SHALL step edit_hours +1 with wrap 23->0, and a btn_dec press SHALL step it -1 with wrap 0->23.
REQ-018 In EDIT_M, btn_inc/btn_dec presses SHALL step edit_minutes with wrap 59->0 / 0->59.
REQ-019 A btn_mode press in EDIT_H SHALL enter EDIT_M; a btn_mode press in EDIT_M SHALL enter COMMIT.
REQ-020 Simultaneous inc and dec presses SHALL leave the value unchanged; btn_mode SHALL take priority over inc/dec in the same cycle, with no value step.
REQ-021 COMMIT SHALL last exactly one cycle; on entry edge, set_hours/set_minutes SHALL take the edit values and set_alarm SHALL be 1 for that cycle only; the next state SHALL be IDLE.
REQ-022 Latency: set_alarm SHALL be high in the cycle immediately after the cycle in which the btn_mode press is sampled in EDIT_M.
REQ-023 set_hours/set_minutes SHALL change only in COMMIT.
REQ-024 A timeout counter SHALL clear on any press (and auto-repeat step) in EDIT_H/EDIT_M; on reaching TIMEOUT_CYCLES, the FSM SHALL go to IDLE without set_alarm and without changing set_*.
REQ-025 In IDLE, inc/dec SHALL be ignored.
REQ-026 edit_field SHALL be 01 in EDIT_H, 10 in EDIT_M, and 00 otherwise.

Reset
REQ-027 rst low SHALL asynchronously force IDLE, set_hours=0, set_minutes=0, edit_*=0, set_alarm=0, edit_field=00, counters and edge registers 0.
REQ-028 Reset mid-edit SHALL discard the edit, and no set_alarm SHALL follow release.

Configuration
REQ-029 With ALARM_SETTER_AUTOREPEAT_EN defined, holding btn_inc or btn_dec alone (other low) in an edit state SHALL produce a step REPEAT_DELAY cycles after the press, then every REPEAT_PERIOD cycles while held; a release or a mode press SHALL stop repeat.
REQ-030 Without ALARM_SETTER_AUTOREPEAT_EN, only press edges SHALL step values; the REPEAT_* parameters SHALL be unused and the repeat counter SHALL not be built.

Verification (TIMEOUT_CYCLES=100, REPEAT_DELAY=20, REPEAT_PERIOD=4)
REQ-031 Bench SHALL cover: after reset, mode, 2x inc, mode, 3x dec, mode -> set_alarm one cycle, set_hours=2, set_minutes=57.
REQ-032 Bench SHALL cover: hours at 23, inc -> 0; minutes at 0, dec -> 59; minutes at 59, inc -> 0.
REQ-033 Bench SHALL cover: enter EDIT_H, inc once, idle 100 cycles -> IDLE, edit_field=00, set_hours stays 0, no set_alarm.
REQ-034 Bench SHALL cover: inc and dec pressed in the same cycle -> value unchanged; mode+inc in the same cycle in EDIT_H -> EDIT_M, hours unchanged.
REQ-035 Bench SHALL cover: rst low in EDIT_M with edit_minutes=30 -> all outputs 0 immediately, no set_alarm after release.
REQ-036 Bench SHALL cover, with macro defined: inc held 32 cycles in EDIT_M from 0 -> edit_minutes=1 after press, 2 at +20, then 3, 4, 5 at +24, +28, +32; without the macro, edit_minutes=1.
